inst_encoder: RTL and testbench

Sequential RV32I instruction encoder: accepts field-level instruction requests (op class, funct3, register indices, immediate) over a valid/ready handshake and emits 32-bit instruction words over a second valid/ready handshake. It also expands the `li` pseudo-op into an LUI/ADDI pair. It feeds the fetch-side instruction path, or the test program loaders, that drive the pipeline's instruction decoder. Its encodings must decode to the same ASel/BSel/ALUSel/PCSel behaviour as the hand-assembled words.

---
 rtl/inst_encoder.sv | 172 +++++++++++++++++
 tb/tb_inst_encoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder with li expansion; word registered one cycle after accept.
// One output slot: req_ready drops while a held word is stalled or an li ADDI is still pending.
module inst_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [2:0]  req_funct3,
   input  logic        req_alt,
   input  logic [4:0]  req_rd,
   input  logic [4:0]  req_rs1,
   input  logic [4:0]  req_rs2,
   input  logic [31:0] req_imm,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic        err
);

   typedef enum logic [1:0] {
      EMPTY     = 2'd0,
      FULL      = 2'd1,
      FULL_PEND = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IALU   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] OP_R      = 4'd0;
   localparam logic [3:0] OP_IALU   = 4'd1;
   localparam logic [3:0] OP_LOAD   = 4'd2;
   localparam logic [3:0] OP_STORE  = 4'd3;
   localparam logic [3:0] OP_BRANCH = 4'd4;
   localparam logic [3:0] OP_LUI    = 4'd5;
   localparam logic [3:0] OP_AUIPC  = 4'd6;
   localparam logic [3:0] OP_JAL    = 4'd7;
   localparam logic [3:0] OP_JALR   = 4'd8;
   localparam logic [3:0] OP_LI     = 4'd9;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] inst_nxt;
   logic [31:0] pend;
   logic [31:0] pend_nxt;
   logic        err_nxt;

   logic [31:0] enc_word;
   logic [31:0] enc_pend;
   logic        enc_pair;
   logic        enc_illegal;
   logic        li_small;
   logic [19:0] li_hi;
   logic [11:0] ialu_hi;

   logic        accept;
   logic        out_hs;

   assign inst_valid = (state != EMPTY);
   assign req_ready  = !reset && (state != FULL_PEND) && ((state == EMPTY) || inst_ready);
   assign accept     = req_valid && req_ready;
   assign out_hs     = inst_valid && inst_ready;

   // Fits ADDI's signed 12-bit immediate when bits 31:11 are a pure sign extension.
   assign li_small = (req_imm[31:11] == {21{req_imm[11]}});
   // (imm + 0x800) >> 12: rounds so the sign-extended ADDI low part restores imm.
   assign li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
   assign ialu_hi  = ((req_funct3 == 3'b001) || (req_funct3 == 3'b101))
                   ? {1'b0, req_alt, 5'b0, req_imm[4:0]}
                   : req_imm[11:0];

   always_comb begin
      enc_word    = NOP;
      enc_pend    = NOP;
      enc_pair    = 1'b0;
      enc_illegal = 1'b0;
      case (req_op)
         OP_R:
            enc_word = {1'b0, req_alt, 5'b0, req_rs2, req_rs1, req_funct3, req_rd, OPC_R};
         OP_IALU:
            enc_word = {ialu_hi, req_rs1, req_funct3, req_rd, OPC_IALU};
         OP_LOAD:
            enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
         OP_STORE:
            enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], OPC_STORE};
         OP_BRANCH: begin
            enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                        req_imm[4:1], req_imm[11], OPC_BRANCH};
            enc_illegal = (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
         end
         OP_LUI:
            enc_word = {req_imm[31:12], req_rd, OPC_LUI};
         OP_AUIPC:
            enc_word = {req_imm[31:12], req_rd, OPC_AUIPC};
         OP_JAL:
            enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OPC_JAL};
         OP_JALR:
            enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OPC_JALR};
         OP_LI: begin
            if (li_small) begin
               enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_IALU};
            end else begin
               enc_word = {li_hi, req_rd, OPC_LUI};
               enc_pend = {req_imm[11:0], req_rd, 3'b000, req_rd, OPC_IALU};
               enc_pair = (req_imm[11:0] != 12'd0);
            end
         end
         default:
            enc_illegal = 1'b1;
      endcase
   end

   always_comb begin
      state_nxt = state;
      inst_nxt  = inst;
      pend_nxt  = pend;
      err_nxt   = 1'b0;
      case (state)
         FULL_PEND: begin
            if (inst_ready) begin
               inst_nxt  = pend;
               state_nxt = FULL;
            end
         end
         EMPTY, FULL: begin
            if (accept) begin
               if (enc_illegal) begin
                  // Accepting in FULL implies the held word also left this cycle.
                  err_nxt   = 1'b1;
                  state_nxt = EMPTY;
               end else begin
                  inst_nxt  = enc_word;
                  if (enc_pair) begin
                     pend_nxt  = enc_pend;
                     state_nxt = FULL_PEND;
                  end else begin
                     state_nxt = FULL;
                  end
               end
            end else if (out_hs) begin
               state_nxt = EMPTY;
            end
         end
         default:
            state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= EMPTY;
         inst  <= NOP;
         pend  <= 32'd0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         inst  <= inst_nxt;
         pend  <= pend_nxt;
         err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: inputs change and outputs are sampled on the falling edge.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [2:0]  req_funct3;
   logic        req_alt;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic        err;

   int passed = 0;
   int total  = 0;

   inst_encoder dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_funct3 (req_funct3),
      .req_alt    (req_alt),
      .req_rd     (req_rd),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_imm    (req_imm),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic put(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
      req_valid  = 1'b1;
      req_op     = op;
      req_funct3 = f3;
      req_alt    = alt;
      req_rd     = rd;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_imm    = imm;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_op = 4'd0; req_funct3 = 3'd0; req_alt = 1'b0;
      req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd0;
      inst_ready = 1'b1;
      step(); step();
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0000_0013);
      chk("rst_err", {31'd0, err}, 32'd0);
      reset = 1'b0;
      #1;
      chk("empty_ready", {31'd0, req_ready}, 32'd1);

      put(4'd1, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
      step();
      chk("addi_valid", {31'd0, inst_valid}, 32'd1);
      chk("addi_word", inst, 32'h0050_0093);
      put(4'd0, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
      step();
      chk("sub_word", inst, 32'h4020_81B3);
      put(4'd4, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8);
      step();
      chk("beq_word", inst, 32'hFE20_8CE3);
      put(4'd3, 3'b010, 1'b0, 5'd0, 5'd2, 5'd5, 32'd12);
      step();
      chk("sw_word", inst, 32'h0051_2623);

      put(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
      step();
      chk("li_lui_word", inst, 32'h1234_62B7);
      chk("li_pend_ready", {31'd0, req_ready}, 32'd0);
      put(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
      step();
      chk("li_addi_word", inst, 32'hFFF2_8293);
      chk("li_addi_valid", {31'd0, inst_valid}, 32'd1);
      chk("li_after_ready", {31'd0, req_ready}, 32'd1);
      step();
      chk("li_lui_only", inst, 32'h1234_52B7);
      put(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, -32'sd3);
      step();
      chk("li_small", inst, 32'hFFD0_0293);
      put(4'd1, 3'b101, 1'b1, 5'd2, 5'd3, 5'd0, 32'd7);
      step();
      chk("srai_word", inst, 32'h4071_D113);

      inst_ready = 1'b0;
      put(4'd7, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8);
      #1;
      chk("bp_ready0", {31'd0, req_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_inst", inst, 32'h4071_D113);
         chk("bp_valid", {31'd0, inst_valid}, 32'd1);
         chk("bp_ready", {31'd0, req_ready}, 32'd0);
      end
      inst_ready = 1'b1;
      step();
      chk("jal_word", inst, 32'h0080_00EF);
      put(4'd8, 3'b011, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0);
      step();
      chk("jalr_word", inst, 32'h0000_8067);
      put(4'd5, 3'b000, 1'b0, 5'd10, 5'd0, 5'd0, 32'hABCD_E000);
      step();
      chk("lui_word", inst, 32'hABCD_E537);
      req_valid = 1'b0;
      step();
      chk("drain_valid", {31'd0, inst_valid}, 32'd0);

      put(4'd12, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
      step();
      chk("ill_op_err", {31'd0, err}, 32'd1);
      chk("ill_op_valid", {31'd0, inst_valid}, 32'd0);
      put(4'd4, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
      step();
      chk("ill_br_err", {31'd0, err}, 32'd1);
      chk("ill_br_valid", {31'd0, inst_valid}, 32'd0);
      req_valid = 1'b0;
      step();
      chk("err_clear", {31'd0, err}, 32'd0);
      put(4'd2, 3'b010, 1'b0, 5'd6, 5'd7, 5'd0, 32'd4);
      step();
      chk("lw_word", inst, 32'h0043_A303);
      chk("lw_valid", {31'd0, inst_valid}, 32'd1);

      put(4'd9, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
      step();
      chk("rp_lui", inst, 32'h1234_62B7);
      req_valid = 1'b0;
      inst_ready = 1'b0;
      step();
      chk("rp_hold", inst, 32'h1234_62B7);
      reset = 1'b1;
      inst_ready = 1'b1;
      step();
      chk("rp_valid", {31'd0, inst_valid}, 32'd0);
      chk("rp_inst", inst, 32'h0000_0013);
      chk("rp_ready", {31'd0, req_ready}, 32'd0);
      reset = 1'b0;
      step();
      chk("rp_no_addi", {31'd0, inst_valid}, 32'd0);
      chk("rp_no_addi_inst", inst, 32'h0000_0013);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
